id_stage_bypass: RTL and testbench
==================================

// Module: id_stage_bypass
// PURPOSE
//  Decode stage of the 5-stage MIPS pipeline, placed between IF and EXE. Decodes
//  the MIPS subset, reads the register file and resolves branches/jumps in ID.
//  Successor to the plain decode stage: adds a parametrised operand-bypass network
//  (NUM_FWD in-flight producers plus WB), load-use and RAW interlocking, and a flush input.
//  Exception classification: fetch AdEL, syscall, break, reserved instruction.
// PARAMETERS
//  NUM_FWD  2  number of bypass sources (index 0 = youngest, e.g. EXE; 1 = MEM)
//  FWD_EN   1  1: forward from sources; 0: interlock on any RAW match (no forwarding)
// PORTS
//  clk             in   1            clock
//  reset           in   1            synchronous, active-high
//  es_allowin      in   1            EXE can accept
//  ds_allowin      out  1            ID can accept
//  fs_to_ds_valid  in   1            IF output valid
//  fs_inst         in   32           instruction
//  fs_pc           in   32           instruction PC
//  fs_ex           in   1            fetch address error flagged by IF
//  flush           in   1            exception/eret commit from WB; kill ID contents
//  fwd_valid       in   NUM_FWD      source i holds a live GPR-writing instruction
//  fwd_dest        in   5*NUM_FWD    source i destination register
//  fwd_busy        in   NUM_FWD      source i result not yet available (load in flight)
//  fwd_data        in   32*NUM_FWD   source i result
//  ws_rf_we        in   1            WB regfile write enable
//  ws_rf_waddr     in   5            WB write address
//  ws_rf_wdata     in   32           WB write data
//  ds_to_es_valid  out  1            ID output valid
//  ds_to_es_bus    out  143          {signed_op,ex,excode[4:0],alu_op[11:0],res_from_mem,src1_is_sa,
//                                     src1_is_pc,src2_is_imm,src2_is_8,gr_we,mem_we,dest[4:0],
//                                     imm[15:0],rs_value,rt_value,pc}
//  br_taken        out  1            redirect IF this cycle
//  br_target       out  32           redirect address
// BEHAVIOUR
//  - Reset: ds_valid=0, so ds_to_es_valid=0, br_taken=0, ds_allowin=1.
//  - Regfile: 32x32, contents not reset. r0 reads 0.
//  - Stage register: on fs_to_ds_valid&&ds_allowin, capture {fs_ex,fs_inst,fs_pc}.
//    ds_allowin = !ds_valid || (ds_ready_go && es_allowin).
//    ds_to_es_valid = ds_valid && ds_ready_go && !flush.
//  - flush: ds_valid<=0 at the next edge, overriding a capture. During the flush cycle,
//    br_taken=0 and ds_to_es_valid=0.
//  - Decode: addu subu slt sltu and or xor nor sll srl sra addiu lui lw sw beq bne jal jr
//    syscall break. The alu_op one-hot mapping is unchanged from the existing pipeline.
//    signed_op=~func[0]. dest: 31 for jal, rt for addiu/lui/lw, else rd.
//  - Operand use: rs is used by all except sll/srl/sra/lui/jal.
//    rt is used by R-type ALU ops, shifts, sw, beq and bne.
//  - Bypass: for each used operand with address != 0, select the lowest i with
//    fwd_valid[i] && fwd_dest[i]==addr. If none matches, use WB if ws_rf_we && waddr==addr.
//    Otherwise use regfile data.
//  - Stall: ds_ready_go=0 when the selected source has fwd_busy=1.
//    With FWD_EN=0, also stall on any fwd match; WB data is still used.
//    While stalled: ds_to_es_valid=0, br_taken=0, and the stage register holds.
//  - Exceptions, first match wins: fs_ex -> 0x04; break -> 0x09; syscall -> 0x08;
//    undecoded -> 0x0a. ex=1 forces gr_we=0, mem_we=0, br_taken=0. excode=0 when ex=0.
//  - Branch: br_taken = ds_valid && ds_ready_go && !flush && !ex &&
//    (beq&&eq || bne&&!eq || jal || jr). eq compares the bypassed rs and rt values.
//    beq/bne target = pc+4+sext(imm)<<2. jal target = {pc+4[31:28],jidx,2'b0}.
//    jr target = rs_value. jal links pc+8 via src1_is_pc/src2_is_8.
//  - Latency: an unstalled instruction presents its outputs combinationally during the
//    cycle it resides in ID. Simultaneous capture and flush: flush wins.
// TESTING
//  - addiu r1 in src0 (data 5), then addu r2,r1,r1 -> rs_value=rt_value=5, no stall.
//  - lw r3 in src0 busy, beq r3,r0 -> 1 cycle ds_to_es_valid=0, ds_allowin=0;
//    next cycle src1 data 0 -> br_taken=1, target=pc+4+off.
//  - src0 and src1 both dest r4 (7 / 9) -> rs_value=7. WB r4=11 only -> rs_value=11.
//  - FWD_EN=0, addu needs r5 held in src1 -> stall until the match clears, then
//    value taken from WB or regfile.
//  - flush asserted during a load-use stall -> ds_valid=0 next cycle, no br_taken,
//    no ds_to_es_valid.
//  - inst 0xFC000000 -> ex=1, excode=0x0a, gr_we=0.
//    fs_ex=1 with a syscall word -> excode=0x04.

Source files
------------

// File: rtl/id_stage_bypass.sv
// ID stage of the 5-stage MIPS pipeline: decode, register file, branch
// resolution, and an operand bypass network with load-use / RAW interlocks.

// Per-operand bypass select: youngest in-flight producer, then WB, then regfile.
module id_opnd_bypass #(
    parameter int NUM_FWD = 2,
    parameter bit FWD_EN  = 1'b1
) (
    input  logic                   used,
    input  logic [4:0]             addr,
    input  logic [NUM_FWD-1:0]     fwd_valid,
    input  logic [5*NUM_FWD-1:0]   fwd_dest,
    input  logic [NUM_FWD-1:0]     fwd_busy,
    input  logic [32*NUM_FWD-1:0]  fwd_data,
    input  logic                   ws_rf_we,
    input  logic [4:0]             ws_rf_waddr,
    input  logic [31:0]            ws_rf_wdata,
    input  logic [31:0]            rf_data,
    output logic [31:0]            value,
    output logic                   stall
);
    logic        hit, hit_busy;
    logic [31:0] hit_data;
    logic        active, wb_hit;

    assign active = used && (addr != 5'd0);
    assign wb_hit = ws_rf_we && (ws_rf_waddr == addr);

    // Scan oldest to youngest so the lowest-index (youngest) match overrides
    always_comb begin
        hit      = 1'b0;
        hit_busy = 1'b0;
        hit_data = '0;
        for (int i = NUM_FWD - 1; i >= 0; i--) begin
            if (fwd_valid[i] && (fwd_dest[i*5 +: 5] == addr)) begin
                hit      = 1'b1;
                hit_busy = fwd_busy[i];
                hit_data = fwd_data[i*32 +: 32];
            end
        end
    end

    // Operand mux; without forwarding any in-flight match interlocks
    always_comb begin
        value = rf_data;
        stall = 1'b0;
        if (active) begin
            if (hit && FWD_EN) begin
                value = hit_data;
                stall = hit_busy;
            end else begin
                if (wb_hit) value = ws_rf_wdata;
                stall = hit;
            end
        end
    end
endmodule

module id_stage_bypass #(
    parameter int NUM_FWD = 2,
    parameter bit FWD_EN  = 1'b1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   es_allowin,
    output logic                   ds_allowin,
    input  logic                   fs_to_ds_valid,
    input  logic [31:0]            fs_inst,
    input  logic [31:0]            fs_pc,
    input  logic                   fs_ex,
    input  logic                   flush,
    input  logic [NUM_FWD-1:0]     fwd_valid,
    input  logic [5*NUM_FWD-1:0]   fwd_dest,
    input  logic [NUM_FWD-1:0]     fwd_busy,
    input  logic [32*NUM_FWD-1:0]  fwd_data,
    input  logic                   ws_rf_we,
    input  logic [4:0]             ws_rf_waddr,
    input  logic [31:0]            ws_rf_wdata,
    output logic                   ds_to_es_valid,
    output logic [142:0]           ds_to_es_bus,
    output logic                   br_taken,
    output logic [31:0]            br_target
);
    logic        ds_valid, ds_fs_ex, ds_ready_go;
    logic [31:0] ds_inst, ds_pc;

    logic [5:0]  op, func;
    logic [4:0]  rs, rt, rd, dest;
    logic [15:0] imm;
    logic [25:0] jidx;

    assign op   = ds_inst[31:26];
    assign rs   = ds_inst[25:21];
    assign rt   = ds_inst[20:16];
    assign rd   = ds_inst[15:11];
    assign func = ds_inst[5:0];
    assign imm  = ds_inst[15:0];
    assign jidx = ds_inst[25:0];

    logic rtype;
    logic inst_addu, inst_subu, inst_slt, inst_sltu, inst_and, inst_or, inst_xor, inst_nor;
    logic inst_sll, inst_srl, inst_sra, inst_jr, inst_syscall, inst_break;
    logic inst_addiu, inst_lui, inst_lw, inst_sw, inst_beq, inst_bne, inst_jal;
    logic decoded;

    assign rtype        = (op == 6'h00);
    assign inst_addu    = rtype && (func == 6'h21);
    assign inst_subu    = rtype && (func == 6'h23);
    assign inst_slt     = rtype && (func == 6'h2a);
    assign inst_sltu    = rtype && (func == 6'h2b);
    assign inst_and     = rtype && (func == 6'h24);
    assign inst_or      = rtype && (func == 6'h25);
    assign inst_xor     = rtype && (func == 6'h26);
    assign inst_nor     = rtype && (func == 6'h27);
    assign inst_sll     = rtype && (func == 6'h00);
    assign inst_srl     = rtype && (func == 6'h02);
    assign inst_sra     = rtype && (func == 6'h03);
    assign inst_jr      = rtype && (func == 6'h08);
    assign inst_syscall = rtype && (func == 6'h0c);
    assign inst_break   = rtype && (func == 6'h0d);
    assign inst_addiu   = (op == 6'h09);
    assign inst_lui     = (op == 6'h0f);
    assign inst_lw      = (op == 6'h23);
    assign inst_sw      = (op == 6'h2b);
    assign inst_beq     = (op == 6'h04);
    assign inst_bne     = (op == 6'h05);
    assign inst_jal     = (op == 6'h03);

    assign decoded = inst_addu | inst_subu | inst_slt | inst_sltu | inst_and | inst_or |
                     inst_xor | inst_nor | inst_sll | inst_srl | inst_sra | inst_jr |
                     inst_syscall | inst_break | inst_addiu | inst_lui | inst_lw |
                     inst_sw | inst_beq | inst_bne | inst_jal;

    logic [11:0] alu_op;
    assign alu_op[0]  = inst_addu | inst_addiu | inst_lw | inst_sw | inst_jal;
    assign alu_op[1]  = inst_subu;
    assign alu_op[2]  = inst_slt;
    assign alu_op[3]  = inst_sltu;
    assign alu_op[4]  = inst_and;
    assign alu_op[5]  = inst_nor;
    assign alu_op[6]  = inst_or;
    assign alu_op[7]  = inst_xor;
    assign alu_op[8]  = inst_sll;
    assign alu_op[9]  = inst_srl;
    assign alu_op[10] = inst_sra;
    assign alu_op[11] = inst_lui;

    logic rs_used, rt_used;
    assign rs_used = inst_addu | inst_subu | inst_slt | inst_sltu | inst_and | inst_or |
                     inst_xor | inst_nor | inst_addiu | inst_lw | inst_sw | inst_beq |
                     inst_bne | inst_jr;
    assign rt_used = inst_addu | inst_subu | inst_slt | inst_sltu | inst_and | inst_or |
                     inst_xor | inst_nor | inst_sll | inst_srl | inst_sra | inst_sw |
                     inst_beq | inst_bne;

    assign dest = inst_jal ? 5'd31 : ((inst_addiu | inst_lui | inst_lw) ? rt : rd);

    // Register file: contents are not reset, r0 reads as zero
    logic [31:0] rf [32];
    logic [31:0] rf_rs, rf_rt;

    // WB write port
    always_ff @(posedge clk) begin
        if (ws_rf_we && (ws_rf_waddr != 5'd0)) rf[ws_rf_waddr] <= ws_rf_wdata;
    end

    assign rf_rs = (rs == 5'd0) ? 32'd0 : rf[rs];
    assign rf_rt = (rt == 5'd0) ? 32'd0 : rf[rt];

    logic [31:0] rs_value, rt_value;
    logic        rs_stall, rt_stall;

    id_opnd_bypass #(.NUM_FWD(NUM_FWD), .FWD_EN(FWD_EN)) u_byp_rs (
        .used(rs_used), .addr(rs), .fwd_valid(fwd_valid), .fwd_dest(fwd_dest),
        .fwd_busy(fwd_busy), .fwd_data(fwd_data), .ws_rf_we(ws_rf_we),
        .ws_rf_waddr(ws_rf_waddr), .ws_rf_wdata(ws_rf_wdata), .rf_data(rf_rs),
        .value(rs_value), .stall(rs_stall)
    );

    id_opnd_bypass #(.NUM_FWD(NUM_FWD), .FWD_EN(FWD_EN)) u_byp_rt (
        .used(rt_used), .addr(rt), .fwd_valid(fwd_valid), .fwd_dest(fwd_dest),
        .fwd_busy(fwd_busy), .fwd_data(fwd_data), .ws_rf_we(ws_rf_we),
        .ws_rf_waddr(ws_rf_waddr), .ws_rf_wdata(ws_rf_wdata), .rf_data(rf_rt),
        .value(rt_value), .stall(rt_stall)
    );

    assign ds_ready_go    = !rs_stall && !rt_stall;
    assign ds_allowin     = !ds_valid || (ds_ready_go && es_allowin);
    assign ds_to_es_valid = ds_valid && ds_ready_go && !flush;

    // Stage valid: flush kills contents and beats a simultaneous capture
    always_ff @(posedge clk) begin
        if (reset)           ds_valid <= 1'b0;
        else if (flush)      ds_valid <= 1'b0;
        else if (ds_allowin) ds_valid <= fs_to_ds_valid;
    end

    // Stage payload; holds while stalled because ds_allowin is low
    always_ff @(posedge clk) begin
        if (fs_to_ds_valid && ds_allowin) begin
            ds_fs_ex <= fs_ex;
            ds_inst  <= fs_inst;
            ds_pc    <= fs_pc;
        end
    end

    // Exception classification, fetch error has highest priority
    logic       ex;
    logic [4:0] excode;
    always_comb begin
        ex     = ds_fs_ex | inst_break | inst_syscall | !decoded;
        excode = 5'h00;
        if (ds_fs_ex)          excode = 5'h04;
        else if (inst_break)   excode = 5'h09;
        else if (inst_syscall) excode = 5'h08;
        else if (!decoded)     excode = 5'h0a;
    end

    logic gr_we, mem_we;
    assign gr_we  = !ex && !(inst_sw | inst_beq | inst_bne | inst_jr);
    assign mem_we = !ex && inst_sw;

    // Branch / jump resolution on bypassed operands
    logic [31:0] pc4;
    logic        br_cond;
    assign pc4     = ds_pc + 32'd4;
    assign br_cond = (inst_beq && (rs_value == rt_value)) ||
                     (inst_bne && (rs_value != rt_value)) || inst_jal || inst_jr;
    assign br_taken = ds_valid && ds_ready_go && !flush && !ex && br_cond;

    // Redirect address by branch kind
    always_comb begin
        br_target = pc4 + {{14{imm[15]}}, imm, 2'b00};
        if (inst_jal)     br_target = {pc4[31:28], jidx, 2'b00};
        else if (inst_jr) br_target = rs_value;
    end

    assign ds_to_es_bus = {~func[0], ex, excode, alu_op, inst_lw,
                           inst_sll | inst_srl | inst_sra, inst_jal,
                           inst_addiu | inst_lui | inst_lw | inst_sw, inst_jal,
                           gr_we, mem_we, dest, imm, rs_value, rt_value, ds_pc};
endmodule

// File: tb/tb_id_stage_bypass.sv
// Bench for id_stage_bypass: two instances (forwarding on / off) share inputs,
// each tracked by a mnemonic-table reference model; directed steps then random.
module tb_id_stage_bypass;
    localparam int NF = 2;
    // mnemonic table: addu subu slt sltu and or xor nor sll srl sra addiu lui lw sw beq bne jal jr syscall break
    localparam int OPC [0:20] = '{0,0,0,0,0,0,0,0,0,0,0,9,15,35,43,4,5,3,0,0,0};
    localparam int FNC [0:20] = '{33,35,42,43,36,37,38,39,0,2,3,0,0,0,0,0,0,0,8,12,13};
    localparam int ALU [0:20] = '{0,1,2,3,4,6,7,5,8,9,10,0,11,0,0,-1,-1,0,-1,-1,-1};

    logic clk = 1'b0, reset, es_allowin, fs_to_ds_valid, fs_ex, flush;
    logic [31:0] fs_inst, fs_pc;
    logic [NF-1:0] fwd_valid, fwd_busy;
    logic [5*NF-1:0] fwd_dest;
    logic [32*NF-1:0] fwd_data;
    logic ws_rf_we;
    logic [4:0] ws_rf_waddr;
    logic [31:0] ws_rf_wdata;

    logic [1:0] out_v, out_a, out_br;
    logic [31:0] out_t [2];
    logic [142:0] out_bus [2];

    int checks = 0, failures = 0;

    // model state, index 0 = forwarding instance, 1 = interlock-only instance
    bit m_valid [2];
    logic [31:0] m_inst [2], m_pc [2];
    bit m_ex [2];
    logic [31:0] rf_m [32];
    bit e_v [2], e_a [2], e_br [2];
    logic [31:0] e_t [2];
    logic [142:0] e_bus [2];

    always #5 clk = ~clk;

    id_stage_bypass #(.NUM_FWD(NF), .FWD_EN(1'b1)) u_fwd (
        .clk(clk), .reset(reset), .es_allowin(es_allowin), .ds_allowin(out_a[0]),
        .fs_to_ds_valid(fs_to_ds_valid), .fs_inst(fs_inst), .fs_pc(fs_pc), .fs_ex(fs_ex),
        .flush(flush), .fwd_valid(fwd_valid), .fwd_dest(fwd_dest), .fwd_busy(fwd_busy),
        .fwd_data(fwd_data), .ws_rf_we(ws_rf_we), .ws_rf_waddr(ws_rf_waddr),
        .ws_rf_wdata(ws_rf_wdata), .ds_to_es_valid(out_v[0]), .ds_to_es_bus(out_bus[0]),
        .br_taken(out_br[0]), .br_target(out_t[0])
    );

    id_stage_bypass #(.NUM_FWD(NF), .FWD_EN(1'b0)) u_nofwd (
        .clk(clk), .reset(reset), .es_allowin(es_allowin), .ds_allowin(out_a[1]),
        .fs_to_ds_valid(fs_to_ds_valid), .fs_inst(fs_inst), .fs_pc(fs_pc), .fs_ex(fs_ex),
        .flush(flush), .fwd_valid(fwd_valid), .fwd_dest(fwd_dest), .fwd_busy(fwd_busy),
        .fwd_data(fwd_data), .ws_rf_we(ws_rf_we), .ws_rf_waddr(ws_rf_waddr),
        .ws_rf_wdata(ws_rf_wdata), .ds_to_es_valid(out_v[1]), .ds_to_es_bus(out_bus[1]),
        .br_taken(out_br[1]), .br_target(out_t[1])
    );

    task automatic chk(input string tag, input logic [142:0] obs, input logic [142:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int mnem(input logic [31:0] w);
        for (int m = 0; m <= 20; m++)
            if (int'(w[31:26]) == OPC[m] && (OPC[m] != 0 || int'(w[5:0]) == FNC[m])) return m;
        return -1;
    endfunction

    // operand value/stall from priority rules: first matching source, else WB, else regfile
    task automatic resolve(input bit fen, input logic [4:0] a, input bit used,
                           output logic [31:0] val, output bit stl);
        int hit = -1;
        val = rf_m[a];
        stl = 1'b0;
        if (!used || a == 5'd0) return;
        for (int i = 0; i < NF; i++)
            if (fwd_valid[i] && fwd_dest[i*5 +: 5] == a) begin hit = i; break; end
        if (hit >= 0 && fen) begin
            val = fwd_data[hit*32 +: 32];
            stl = fwd_busy[hit];
            return;
        end
        if (hit >= 0) stl = 1'b1;
        if (ws_rf_we && ws_rf_waddr == a) val = ws_rf_wdata;
    endtask

    task automatic model_eval(input int k);
        logic [31:0] w, rsv, rtv, pc4, off;
        logic [4:0] ec, dst;
        logic [11:0] alu;
        bit srs, srt, rdy, ex, cond, urs, urt;
        int m;
        w = m_inst[k];
        m = mnem(w);
        urs = m inside {[0:7], 11, 13, 14, 15, 16, 18};
        urt = m inside {[0:10], 14, 15, 16};
        resolve(k == 0, w[25:21], urs, rsv, srs);
        resolve(k == 0, w[20:16], urt, rtv, srt);
        rdy = !srs && !srt;
        ex = m_ex[k] || m == 19 || m == 20 || m < 0;
        ec = m_ex[k] ? 5'h04 : (m == 20) ? 5'h09 : (m == 19) ? 5'h08 : (m < 0) ? 5'h0a : 5'h00;
        alu = '0;
        if (m >= 0 && ALU[m] >= 0) alu[ALU[m]] = 1'b1;
        dst = (m == 17) ? 5'd31 : (m inside {11, 12, 13}) ? w[20:16] : w[15:11];
        cond = (m == 15 && rsv == rtv) || (m == 16 && rsv != rtv) || m == 17 || m == 18;
        pc4 = m_pc[k] + 32'd4;
        off = {{16{w[15]}}, w[15:0]};
        e_v[k]  = m_valid[k] && rdy && !flush;
        e_a[k]  = !m_valid[k] || (rdy && es_allowin);
        e_br[k] = e_v[k] && !ex && cond;
        e_t[k]  = (m == 17) ? {pc4[31:28], w[25:0], 2'b00} : (m == 18) ? rsv : pc4 + off * 4;
        e_bus[k] = {~w[0], ex, ec, alu, m == 13, m inside {8, 9, 10}, m == 17,
                    m inside {11, 12, 13, 14}, m == 17, !ex && !(m inside {14, 15, 16, 18}),
                    !ex && m == 14, dst, w[15:0], rsv, rtv, m_pc[k]};
    endtask

    task automatic check_all();
        for (int k = 0; k < 2; k++) begin
            model_eval(k);
            chk($sformatf("valid%0d", k), 143'(out_v[k]), 143'(e_v[k]));
            chk($sformatf("allowin%0d", k), 143'(out_a[k]), 143'(e_a[k]));
            chk($sformatf("br_taken%0d", k), 143'(out_br[k]), 143'(e_br[k]));
            if (e_br[k]) chk($sformatf("br_target%0d", k), 143'(out_t[k]), 143'(e_t[k]));
            if (e_v[k]) chk($sformatf("bus%0d", k), out_bus[k], e_bus[k]);
        end
    endtask

    task automatic model_upd();
        for (int k = 0; k < 2; k++) begin
            if (flush) m_valid[k] = 1'b0;
            else if (e_a[k]) begin
                m_valid[k] = fs_to_ds_valid;
                if (fs_to_ds_valid) begin
                    m_inst[k] = fs_inst;
                    m_pc[k] = fs_pc;
                    m_ex[k] = fs_ex;
                end
            end
        end
        if (ws_rf_we && ws_rf_waddr != 5'd0) rf_m[ws_rf_waddr] = ws_rf_wdata;
    endtask

    task automatic tick_neg();
        @(negedge clk);
        check_all();
    endtask

    task automatic tick_pos();
        @(posedge clk);
        model_upd();
        #1;
    endtask

    task automatic idle();
        es_allowin = 1'b1; fs_to_ds_valid = 1'b0; fs_inst = '0; fs_pc = '0; fs_ex = 1'b0;
        flush = 1'b0; fwd_valid = '0; fwd_dest = '0; fwd_busy = '0; fwd_data = '0;
        ws_rf_we = 1'b0; ws_rf_waddr = '0; ws_rf_wdata = '0;
    endtask

    task automatic drain();
        idle();
        repeat (2) begin tick_neg(); tick_pos(); end
    endtask

    task automatic set_src(input int i, input bit v, input logic [4:0] d, input bit b,
                           input logic [31:0] dat);
        fwd_valid[i] = v; fwd_dest[i*5 +: 5] = d; fwd_busy[i] = b; fwd_data[i*32 +: 32] = dat;
    endtask

    task automatic capture(input logic [31:0] w, input logic [31:0] pc, input bit fex);
        fs_to_ds_valid = 1'b1; fs_inst = w; fs_pc = pc; fs_ex = fex;
        tick_neg(); tick_pos();
        fs_to_ds_valid = 1'b0; fs_ex = 1'b0;
    endtask

    function automatic logic [31:0] rand_inst();
        int m = $urandom_range(0, 22);
        logic [4:0] a = 5'($urandom_range(0, 5)), b = 5'($urandom_range(0, 5));
        logic [4:0] c = 5'($urandom_range(0, 5));
        logic [31:0] r = $urandom;
        if (m == 21) return 32'hFC000000 | (r & 32'h03FFFFFF);
        if (m == 22) return r;
        if (m == 17) return {6'd3, r[25:0]};
        if (OPC[m] == 0) return {6'd0, a, b, c, r[10:6], 6'(FNC[m])};
        return {6'(OPC[m]), a, b, r[15:0]};
    endfunction

    initial begin
        for (int k = 0; k < 2; k++) begin
            m_valid[k] = 1'b0; m_inst[k] = '0; m_pc[k] = '0; m_ex[k] = 1'b0;
        end
        for (int r = 0; r < 32; r++) rf_m[r] = '0;
        idle();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        // reset state
        tick_neg();
        chk("reset_allowin", 143'(out_a[0]), 143'(1'b1));
        chk("reset_valid", 143'(out_v[0]), 143'(1'b0));
        tick_pos();

        // preload the register file through the WB port
        for (int r = 1; r < 32; r++) begin
            ws_rf_we = 1'b1; ws_rf_waddr = 5'(r); ws_rf_wdata = $urandom;
            tick_neg(); tick_pos();
        end
        drain();

        // addiu r1 in src0 (5) then addu r2,r1,r1: no stall when forwarding
        set_src(0, 1, 5'd1, 0, 32'd5);
        capture(32'h00211021, 32'h0000_0100, 1'b0);
        tick_neg();
        chk("fwd_rs5", 143'(out_bus[0][95:64]), 143'(32'd5));
        chk("fwd_rt5", 143'(out_bus[0][63:32]), 143'(32'd5));
        chk("fwd_valid", 143'(out_v[0]), 143'(1'b1));
        tick_pos();
        drain();

        // load-use: beq r3,r0 with r3 busy in src0, then data 0 from src1
        set_src(0, 1, 5'd3, 1, 32'hDEAD_BEEF);
        capture(32'h10600002, 32'h0000_1000, 1'b0);
        tick_neg();
        chk("lu_stall_valid", 143'(out_v[0]), 143'(1'b0));
        chk("lu_stall_allowin", 143'(out_a[0]), 143'(1'b0));
        tick_pos();
        set_src(0, 0, 5'd0, 0, 32'd0);
        set_src(1, 1, 5'd3, 0, 32'd0);
        tick_neg();
        chk("lu_br_taken", 143'(out_br[0]), 143'(1'b1));
        chk("lu_br_target", 143'(out_t[0]), 143'(32'h0000_100C));
        tick_pos();
        drain();

        // src0/src1 both write r4: youngest wins; then WB only
        es_allowin = 1'b0;
        set_src(0, 1, 5'd4, 0, 32'd7);
        set_src(1, 1, 5'd4, 0, 32'd9);
        capture(32'h00803021, 32'h0000_2000, 1'b0);
        tick_neg();
        chk("prio_rs7", 143'(out_bus[0][95:64]), 143'(32'd7));
        tick_pos();
        fwd_valid = '0;
        ws_rf_we = 1'b1; ws_rf_waddr = 5'd4; ws_rf_wdata = 32'd11;
        tick_neg();
        chk("wb_rs11", 143'(out_bus[0][95:64]), 143'(32'd11));
        tick_pos();
        drain();

        // no-forwarding instance interlocks on r5 in src1 until it clears
        set_src(1, 1, 5'd5, 0, 32'd3);
        capture(32'h00A03821, 32'h0000_3000, 1'b0);
        tick_neg();
        chk("nofwd_stall", 143'(out_v[1]), 143'(1'b0));
        chk("fwd_no_stall", 143'(out_bus[0][95:64]), 143'(32'd3));
        tick_pos();
        fwd_valid = '0;
        ws_rf_we = 1'b1; ws_rf_waddr = 5'd5; ws_rf_wdata = 32'd13;
        tick_neg();
        chk("nofwd_release", 143'(out_v[1]), 143'(1'b1));
        chk("nofwd_wb13", 143'(out_bus[1][95:64]), 143'(32'd13));
        tick_pos();
        drain();

        // flush during a load-use stall
        set_src(0, 1, 5'd3, 1, 32'd0);
        capture(32'h10600002, 32'h0000_4000, 1'b0);
        tick_neg(); tick_pos();
        flush = 1'b1;
        tick_neg();
        chk("flush_br", 143'(out_br[0]), 143'(1'b0));
        chk("flush_valid", 143'(out_v[0]), 143'(1'b0));
        tick_pos();
        flush = 1'b0;
        tick_neg();
        chk("post_flush_allowin", 143'(out_a[0]), 143'(1'b1));
        tick_pos();
        drain();

        // reserved instruction and fetch-error priority
        capture(32'hFC000000, 32'h0000_5000, 1'b0);
        tick_neg();
        chk("ri_ex", 143'(out_bus[0][141]), 143'(1'b1));
        chk("ri_excode", 143'(out_bus[0][140:136]), 143'(5'h0a));
        chk("ri_gr_we", 143'(out_bus[0][118]), 143'(1'b0));
        tick_pos();
        capture(32'h0000000C, 32'h0000_6000, 1'b1);
        tick_neg();
        chk("adel_excode", 143'(out_bus[0][140:136]), 143'(5'h04));
        tick_pos();
        drain();

        // randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            es_allowin = ($urandom_range(0, 4) != 0);
            fs_to_ds_valid = ($urandom_range(0, 9) < 7);
            fs_inst = rand_inst();
            fs_pc = {$urandom_range(0, 32'hFFFF), 2'b00};
            fs_ex = ($urandom_range(0, 15) == 0);
            flush = ($urandom_range(0, 31) == 0);
            for (int i = 0; i < NF; i++)
                set_src(i, $urandom_range(0, 1) == 1, 5'($urandom_range(0, 5)),
                        $urandom_range(0, 5) == 0, $urandom);
            ws_rf_we = ($urandom_range(0, 1) == 1);
            ws_rf_waddr = 5'($urandom_range(0, 6));
            ws_rf_wdata = $urandom;
            tick_neg(); tick_pos();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
